fifo3_seq_ctrl: RTL and testbench
=================================

// Module: fifo3_seq_ctrl
// PURPOSE
//  Sequencing controller for the 3-entry x 32-bit FIFO between instruction fetch (producer) and decode (consumer).
//  Converts valid/ready handshakes on both sides into the FIFO's wren/rden/pointer-clear strobes.
//  Tracks occupancy, prevents overflow/underflow, wraps the FIFO's 3-bit pointers at DEPTH and flushes on redirect.
//  The 32-bit data path runs directly between producer, FIFO and consumer; this block sees no data.
// PARAMETERS
//  DEPTH   3  number of FIFO entries; legal range 2..7
//  CNT_W   2  occupancy/index width, ceil(log2(DEPTH+1))
// PORTS
//  clk            in   1      single clock; all state updates on posedge
//  rst            in   1      synchronous, active-high reset
//  wr_valid       in   1      producer offers a word this cycle
//  wr_ready       out  1      controller accepts; write fires on wr_valid & wr_ready
//  rd_req         in   1      consumer requests a word
//  rd_grant       out  1      read issued to FIFO this cycle
//  rd_data_valid  out  1      FIFO DataOut holds granted word (1 cycle after rd_grant)
//  flush          in   1      branch redirect; discard all contents
//  fifo_wren      out  1      to FIFO wren
//  fifo_rden      out  1      to FIFO rden
//  fifo_wrptr_clr out  1      to FIFO WrPtrClr
//  fifo_rdptr_clr out  1      to FIFO RdPtrClr
//  count          out  CNT_W  current occupancy 0..DEPTH
//  empty          out  1      count==0
//  full           out  1      count==DEPTH
//  ovf_err        out  1      sticky overflow-attempt flag (FIFO_ERR_EN only, else tied 0)
//  udf_err        out  1      sticky underflow-attempt flag (FIFO_ERR_EN only, else tied 0)
// BEHAVIOUR
//  Reset: state=FLUSH for one cycle, then EMPTY. During FLUSH: fifo_wrptr_clr=fifo_rdptr_clr=1.
//   All other outputs 0 except empty=1; count=0; wr_idx=rd_idx=0; error flags cleared.
//  States: EMPTY (count==0), ACTIVE (0<count<DEPTH), FULL (count==DEPTH), FLUSH.
//   Transitions are derived from next count; FLUSH is entered on rst or flush and always returns to EMPTY.
//  Write: wr_ready = (state!=FLUSH) & (!full | rd_grant). Full-and-read in the same cycle accepts the write.
//   fifo_wren = wr_valid & wr_ready.
//  Read: rd_grant = rd_req & !empty & (state!=FLUSH). No bypass: with empty=1 a same-cycle write is not readable.
//   fifo_rden = rd_grant. rd_data_valid is rd_grant registered; it is forced to 0 when flush or rst is seen.
//  Count: next = count + wr_fire - rd_grant. Simultaneous write+read leaves count unchanged.
//  Wrap: on a fire with wr_idx==DEPTH-1, assert fifo_wrptr_clr in the same cycle and set wr_idx to 0.
//   The FIFO applies the clear after the write. The read side uses rd_idx / fifo_rdptr_clr the same way.
//  Flush: at the clock edge where flush is sampled high, state->FLUSH; no write or read fires that cycle.
//   Next cycle both pointer clears pulse, count and indices go to 0, rd_data_valid=0. Then EMPTY.
//   Flush held high keeps state in FLUSH.
//  Priority: rst > flush > read/write. Reset mid-operation discards contents with the same sequence as flush.
//  fifo_rden is low on idle cycles, so FIFO DataOut goes to Z; the consumer samples only on rd_data_valid.
// CONFIGURATION
//  FIFO_ERR_EN defined:
//   - ovf_err sets when wr_valid & full & !rd_grant.
//   - udf_err sets when rd_req & empty.
//   - Both flags are sticky until rst; flush does not clear them.
//  FIFO_ERR_EN undefined: no error logic; ovf_err=udf_err=0.
// STRUCTURE
//  Package fifo_ctrl_pkg: state encoding (EMPTY/ACTIVE/FULL/FLUSH, 2 bits), DEPTH default, CNT_W.
//  Sub-module fifo_idx_wrap: index counter 0..DEPTH-1 with inc, clr and wrap-pulse output.
//   Instantiated twice: write side drives fifo_wrptr_clr, read side drives fifo_rdptr_clr.
//  Top holds the state register, occupancy counter, handshake logic and optional error flags.
// TESTING
//  1. Reset release, idle: 1 cycle with both ptr clears=1; then empty=1, count=0, wr_ready=1, rd_grant=0.
//  2. Fill: wr_valid 4 cycles, no reads. Writes 1..3 fire; cycle 4 wr_ready=0, full=1, count=3.
//   fifo_wrptr_clr pulses with the 3rd write.
//  3. Full with simultaneous wr_valid+rd_req: both fire, count stays 3, rd_data_valid=1 next cycle.
//  4. Wrap: 7 writes and 7 reads interleaved. Ptr clears pulse on every 3rd fire per side.
//   Read order matches write order 0xA0..0xA6.
//  5. Flush with count=2 and rd_req held: FLUSH cycle has both clears=1 and rd_grant=0. Next cycle count=0, empty=1.
//  6. FIFO_ERR_EN: rd_req while empty -> udf_err=1 and stays 1 after flush. Write while full -> ovf_err=1. rst clears both.

Source files
------------

// File: rtl/fifo3_seq_ctrl_pkg.sv
// Shared state encoding and sizing for the fetch->decode FIFO sequencing controller.
// Optional sticky error flags are enabled by defining FIFO_ERR_EN.
package fifo_ctrl_pkg;
    localparam int DEPTH_DEF = 3;
    localparam int CNT_W_DEF = $clog2(DEPTH_DEF + 1);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2,
        ST_FLUSH  = 2'd3
    } state_e;
endpackage

// File: rtl/fifo3_seq_ctrl_if.sv
// Handshake and FIFO-strobe bundle between fetch/decode (master) and the controller (slave).
interface fifo3_seq_ctrl_if
    import fifo_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             wr_valid;
    logic             wr_ready;
    logic             rd_req;
    logic             rd_grant;
    logic             rd_data_valid;
    logic             flush;
    logic             fifo_wren;
    logic             fifo_rden;
    logic             fifo_wrptr_clr;
    logic             fifo_rdptr_clr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             ovf_err;
    logic             udf_err;

    modport master (
        output wr_valid, rd_req, flush,
        input  wr_ready, rd_grant, rd_data_valid, fifo_wren, fifo_rden,
        input  fifo_wrptr_clr, fifo_rdptr_clr, count, empty, full, ovf_err, udf_err
    );

    modport slave (
        input  wr_valid, rd_req, flush,
        output wr_ready, rd_grant, rd_data_valid, fifo_wren, fifo_rden,
        output fifo_wrptr_clr, fifo_rdptr_clr, count, empty, full, ovf_err, udf_err
    );
endinterface

// File: rtl/fifo3_seq_ctrl_idx_wrap.sv
// Index counter 0..DEPTH-1; o_wrap pulses on the increment that rolls back to 0.
module fifo_idx_wrap #(
    parameter int DEPTH = 3,
    parameter int W     = 2
) (
    input  logic clk,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_wrap
);
    localparam logic [W-1:0] LAST = W'(DEPTH - 1);

    logic [W-1:0] r_idx;

    assign o_wrap = i_inc & (r_idx == LAST);

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= o_wrap ? '0 : r_idx + W'(1);
        end
    end
endmodule

// File: rtl/fifo3_seq_ctrl.sv
// Sequencing controller for the fetch->decode FIFO: handshakes, occupancy, pointer wrap, flush.
// Define FIFO_ERR_EN to build the sticky overflow/underflow flags.
module fifo3_seq_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    fifo3_seq_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_rd_data_valid;
    logic             w_in_flush;
    logic             w_block;
    logic             w_empty;
    logic             w_full;
    logic             w_rd_grant;
    logic             w_wr_ready;
    logic             w_wr_fire;
    logic [1:0]       w_inc;
    logic [1:0]       w_wrap;

    // Nothing may fire while flushing or on the cycle a flush/reset is sampled.
    assign w_in_flush = (r_state == ST_FLUSH);
    assign w_block    = w_in_flush | bus.flush | rst;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == DEPTH_C);
    assign w_rd_grant = bus.rd_req & ~w_empty & ~w_block;
    assign w_wr_ready = ~w_block & (~w_full | w_rd_grant);
    assign w_wr_fire  = bus.wr_valid & w_wr_ready;
    assign w_inc      = {w_rd_grant, w_wr_fire};

    // Index 0 tracks the write pointer, index 1 the read pointer.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_idx
            fifo_idx_wrap #(
                .DEPTH (DEPTH),
                .W     (CNT_W)
            ) u_idx (
                .clk    (clk),
                .i_clr  (rst | bus.flush),
                .i_inc  (w_inc[gi]),
                .o_wrap (w_wrap[gi])
            );
        end
    endgenerate

    always_comb begin
        w_count_next = r_count;
        w_state_next = r_state;
        if (bus.flush) begin
            w_count_next = '0;
            w_state_next = ST_FLUSH;
        end else begin
            if (w_wr_fire & ~w_rd_grant) begin
                w_count_next = r_count + CNT_W'(1);
            end else if (~w_wr_fire & w_rd_grant) begin
                w_count_next = r_count - CNT_W'(1);
            end
            if (w_count_next == '0) begin
                w_state_next = ST_EMPTY;
            end else if (w_count_next == DEPTH_C) begin
                w_state_next = ST_FULL;
            end else begin
                w_state_next = ST_ACTIVE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_FLUSH;
            r_count         <= '0;
            r_rd_data_valid <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_count         <= w_count_next;
            r_rd_data_valid <= w_rd_grant;
        end
    end

    assign bus.wr_ready       = w_wr_ready;
    assign bus.rd_grant       = w_rd_grant;
    assign bus.rd_data_valid  = r_rd_data_valid;
    assign bus.fifo_wren      = w_wr_fire;
    assign bus.fifo_rden      = w_rd_grant;
    assign bus.fifo_wrptr_clr = w_in_flush | w_wrap[0];
    assign bus.fifo_rdptr_clr = w_in_flush | w_wrap[1];
    assign bus.count          = r_count;
    assign bus.empty          = w_empty;
    assign bus.full           = w_full;

`ifdef FIFO_ERR_EN
    logic r_ovf_err;
    logic r_udf_err;

    // Sticky until reset; a flush deliberately leaves them set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            if (bus.wr_valid & w_full & ~w_rd_grant) r_ovf_err <= 1'b1;
            if (bus.rd_req & w_empty)                r_udf_err <= 1'b1;
        end
    end

    assign bus.ovf_err = r_ovf_err;
    assign bus.udf_err = r_udf_err;
`else
    assign bus.ovf_err = 1'b0;
    assign bus.udf_err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo3_seq_ctrl.sv
// Self-checking bench for fifo3_seq_ctrl: directed scenarios plus randomized traffic vs a queue model.
module tb_fifo3_seq_ctrl;
    import fifo_ctrl_pkg::*;

    localparam int D = DEPTH_DEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo3_seq_ctrl_if #(.CNT_W(CNT_W_DEF)) bus();

    fifo3_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural 32-bit FIFO driven only by the controller's strobes.
    logic [31:0] mem [0:7];
    int          wp = 0;
    int          rp = 0;
    logic [31:0] din = '0;
    logic [31:0] dout = '0;

    always @(posedge clk) begin
        if (bus.fifo_wren) mem[wp] <= din;
        if (bus.fifo_wren || bus.fifo_wrptr_clr) wp <= bus.fifo_wrptr_clr ? 0 : wp + 1;
        if (bus.fifo_rden) dout <= mem[rp];
        if (bus.fifo_rden || bus.fifo_rdptr_clr) rp <= bus.fifo_rdptr_clr ? 0 : rp + 1;
    end

    // Reference model: contents as a queue, plus pointer positions for the wrap pulses.
    logic [31:0] m_q[$];
    bit          m_fl = 1'b1;
    int          m_wi = 0;
    int          m_ri = 0;
    bit          m_rdv = 1'b0;
    logic [31:0] m_last = '0;
    bit          m_ovf = 1'b0;
    bit          m_udf = 1'b0;
    bit          e_wr_ready, e_rd_grant, e_wfire, e_wclr, e_rclr;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic calc_exp();
        e_rd_grant = bus.rd_req && (m_q.size() > 0) && !m_fl && !bus.flush && !rst;
        e_wr_ready = !m_fl && !bus.flush && !rst && ((m_q.size() < D) || e_rd_grant);
        e_wfire    = bus.wr_valid && e_wr_ready;
        e_wclr     = m_fl || (e_wfire && (m_wi == D - 1));
        e_rclr     = m_fl || (e_rd_grant && (m_ri == D - 1));
    endtask

    task automatic advance();
        calc_exp();
        @(posedge clk);
`ifdef FIFO_ERR_EN
        if (rst) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (bus.wr_valid && (m_q.size() == D) && !e_rd_grant) m_ovf = 1'b1;
            if (bus.rd_req && (m_q.size() == 0)) m_udf = 1'b1;
        end
`endif
        if (rst || bus.flush) begin
            m_q.delete();
            m_fl  = 1'b1;
            m_wi  = 0;
            m_ri  = 0;
            m_rdv = 1'b0;
        end else begin
            m_fl = 1'b0;
            if (e_rd_grant) begin
                m_last = m_q.pop_front();
                m_ri   = (m_ri == D - 1) ? 0 : m_ri + 1;
            end
            if (e_wfire) begin
                m_q.push_back(din);
                m_wi = (m_wi == D - 1) ? 0 : m_wi + 1;
            end
            m_rdv = e_rd_grant;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        advance();
        advance();
        rst = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.fifo_wrptr_clr, bus.fifo_rdptr_clr} !== 2'b11)
            $display("FAIL reset_ptr_clr: got %b exp 11", {bus.fifo_wrptr_clr, bus.fifo_rdptr_clr});
        else pass_cnt++;
        chk_cnt++;
        if ({bus.empty, bus.wr_ready, bus.rd_grant, bus.full, bus.rd_data_valid} !== 5'b10000)
            $display("FAIL reset_flush_outs: got %b exp 10000",
                     {bus.empty, bus.wr_ready, bus.rd_grant, bus.full, bus.rd_data_valid});
        else pass_cnt++;
        advance();
        chk_cnt++;
        if ({bus.empty, bus.wr_ready, bus.rd_grant, bus.fifo_wrptr_clr, bus.fifo_rdptr_clr} !== 5'b11000
            || bus.count !== '0)
            $display("FAIL reset_idle: got %b cnt %0d exp 11000 cnt 0",
                     {bus.empty, bus.wr_ready, bus.rd_grant, bus.fifo_wrptr_clr, bus.fifo_rdptr_clr}, bus.count);
        else pass_cnt++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1;
            din = 32'h10 + 32'(i);
            #1;
            chk_cnt++;
            if ({bus.wr_ready, bus.fifo_wrptr_clr} !== {1'(i < 3), 1'(i == 2)})
                $display("FAIL fill_%0d: got rdy/clr %b exp %b", i, {bus.wr_ready, bus.fifo_wrptr_clr},
                         {1'(i < 3), 1'(i == 2)});
            else pass_cnt++;
            advance();
        end
        bus.wr_valid = 1'b0;
        #1;
        chk_cnt++;
        if (bus.full !== 1'b1 || bus.count !== 2'd3)
            $display("FAIL fill_full: got full %b cnt %0d exp full 1 cnt 3", bus.full, bus.count);
        else pass_cnt++;
    endtask

    task automatic test_full_rw();
        bus.wr_valid = 1'b1;
        bus.rd_req   = 1'b1;
        din = 32'h20;
        #1;
        chk_cnt++;
        if ({bus.wr_ready, bus.rd_grant, bus.fifo_wren, bus.fifo_rden} !== 4'b1111)
            $display("FAIL full_rw_fire: got %b exp 1111", {bus.wr_ready, bus.rd_grant, bus.fifo_wren, bus.fifo_rden});
        else pass_cnt++;
        advance();
        bus.wr_valid = 1'b0;
        bus.rd_req   = 1'b0;
        #1;
        chk_cnt++;
        if (bus.count !== 2'd3 || bus.rd_data_valid !== 1'b1 || dout !== 32'h10)
            $display("FAIL full_rw_after: got cnt %0d rdv %b data %h exp cnt 3 rdv 1 data 10",
                     bus.count, bus.rd_data_valid, dout);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        bus.flush = 1'b1;
        advance();
        bus.flush = 1'b0;
        advance();
        for (int k = 0; k < 7; k++) begin
            bus.wr_valid = 1'b1;
            bus.rd_req   = 1'b0;
            din = 32'hA0 + 32'(k);
            #1;
            if (k > 0) begin
                chk_cnt++;
                if ({bus.rd_data_valid, dout} !== {1'b1, 32'hA0 + 32'(k - 1)})
                    $display("FAIL wrap_data_%0d: got rdv %b data %h exp rdv 1 data %h",
                             k - 1, bus.rd_data_valid, dout, 32'hA0 + 32'(k - 1));
                else pass_cnt++;
            end
            chk_cnt++;
            if ({bus.fifo_wren, bus.fifo_wrptr_clr} !== {1'b1, 1'((k % 3) == 2)})
                $display("FAIL wrap_wr_%0d: got wren/clr %b exp %b", k, {bus.fifo_wren, bus.fifo_wrptr_clr},
                         {1'b1, 1'((k % 3) == 2)});
            else pass_cnt++;
            advance();
            bus.wr_valid = 1'b0;
            bus.rd_req   = 1'b1;
            #1;
            chk_cnt++;
            if ({bus.rd_grant, bus.fifo_rdptr_clr} !== {1'b1, 1'((k % 3) == 2)})
                $display("FAIL wrap_rd_%0d: got grant/clr %b exp %b", k, {bus.rd_grant, bus.fifo_rdptr_clr},
                         {1'b1, 1'((k % 3) == 2)});
            else pass_cnt++;
            advance();
        end
        bus.rd_req = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.rd_data_valid, dout} !== {1'b1, 32'hA6})
            $display("FAIL wrap_data_6: got rdv %b data %h exp rdv 1 data a6", bus.rd_data_valid, dout);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 2; i++) begin
            bus.wr_valid = 1'b1;
            din = 32'hB0 + 32'(i);
            advance();
        end
        bus.wr_valid = 1'b0;
        bus.rd_req   = 1'b1;
        bus.flush    = 1'b1;
        #1;
        chk_cnt++;
        if (bus.count !== 2'd2 || {bus.rd_grant, bus.wr_ready} !== 2'b00)
            $display("FAIL flush_sample: got cnt %0d grant/rdy %b exp cnt 2 grant/rdy 00",
                     bus.count, {bus.rd_grant, bus.wr_ready});
        else pass_cnt++;
        advance();
        bus.flush = 1'b0;
        #1;
        chk_cnt++;
        if ({bus.fifo_wrptr_clr, bus.fifo_rdptr_clr, bus.rd_grant, bus.rd_data_valid} !== 4'b1100)
            $display("FAIL flush_cycle: got %b exp 1100",
                     {bus.fifo_wrptr_clr, bus.fifo_rdptr_clr, bus.rd_grant, bus.rd_data_valid});
        else pass_cnt++;
        advance();
        chk_cnt++;
        if (bus.count !== '0 || bus.empty !== 1'b1 || bus.rd_grant !== 1'b0)
            $display("FAIL flush_after: got cnt %0d empty %b grant %b exp 0 1 0", bus.count, bus.empty, bus.rd_grant);
        else pass_cnt++;
        bus.rd_req = 1'b0;
    endtask

    task automatic test_errors();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        advance();
        bus.rd_req = 1'b1;
        advance();
        bus.rd_req = 1'b0;
        chk_cnt++;
        if (bus.udf_err !== m_udf)
            $display("FAIL err_udf: got %b exp %b", bus.udf_err, m_udf);
        else pass_cnt++;
        bus.flush = 1'b1;
        advance();
        bus.flush = 1'b0;
        advance();
        chk_cnt++;
        if (bus.udf_err !== m_udf)
            $display("FAIL err_udf_after_flush: got %b exp %b", bus.udf_err, m_udf);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1;
            din = 32'hC0 + 32'(i);
            advance();
        end
        bus.wr_valid = 1'b0;
        chk_cnt++;
        if ({bus.ovf_err, bus.udf_err} !== {m_ovf, m_udf})
            $display("FAIL err_ovf: got ovf/udf %b exp %b", {bus.ovf_err, bus.udf_err}, {m_ovf, m_udf});
        else pass_cnt++;
        rst = 1'b1;
        advance();
        rst = 1'b0;
        advance();
        chk_cnt++;
        if ({bus.ovf_err, bus.udf_err} !== 2'b00)
            $display("FAIL err_rst_clear: got %b exp 00", {bus.ovf_err, bus.udf_err});
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [10:0] got_v;
        logic [10:0] exp_v;
        for (int i = 0; i < 400; i++) begin
            bus.wr_valid = ($urandom_range(0, 2) != 0);
            bus.rd_req   = ($urandom_range(0, 1) != 0);
            bus.flush    = ($urandom_range(0, 19) == 0);
            rst          = ($urandom_range(0, 79) == 0);
            din          = $urandom;
            #1;
            calc_exp();
            got_v = {bus.wr_ready, bus.rd_grant, bus.fifo_wren, bus.fifo_rden, bus.fifo_wrptr_clr,
                     bus.fifo_rdptr_clr, bus.rd_data_valid, bus.empty, bus.full, bus.ovf_err, bus.udf_err};
            exp_v = {e_wr_ready, e_rd_grant, e_wfire, e_rd_grant, e_wclr, e_rclr, m_rdv,
                     1'(m_q.size() == 0), 1'(m_q.size() == D), m_ovf, m_udf};
            chk_cnt++;
            if (got_v !== exp_v)
                $display("FAIL rand_outs_%0d: got %b exp %b", i, got_v, exp_v);
            else pass_cnt++;
            chk_cnt++;
            if (int'(bus.count) !== m_q.size())
                $display("FAIL rand_count_%0d: got %0d exp %0d", i, bus.count, m_q.size());
            else pass_cnt++;
            if (m_rdv) begin
                chk_cnt++;
                if (dout !== m_last)
                    $display("FAIL rand_data_%0d: got %h exp %h", i, dout, m_last);
                else pass_cnt++;
            end
            advance();
        end
        bus.wr_valid = 1'b0;
        bus.rd_req   = 1'b0;
        bus.flush    = 1'b0;
        rst          = 1'b0;
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.rd_req   = 1'b0;
        bus.flush    = 1'b0;
        rst          = 1'b1;
        test_reset();
        test_fill();
        test_full_rw();
        test_wrap();
        test_flush();
        test_errors();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
